// File: rtl/i2c_cmd_arbiter.sv
// rtl/i2c_cmd_arbiter.sv - round-robin arbiter sharing one I2C write engine between two command sources
// NACK retry with idle gap, watchdog abort on a stuck transfer; every output is registered.
module i2c_cmd_arbiter #(
  parameter int MAX_RETRY   = 3,
  parameter int RETRY_GAP   = 1000,
  parameter int TIMEOUT_CYC = 2000000,
  parameter int TO_W        = 21
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req0_valid,
  input  logic [23:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [23:0] req1_data,
  output logic        req1_ready,
  output logic        done,
  output logic        done_id,
  output logic        done_err,
  output logic        timeout_flag,
  output logic        busy,
  output logic [23:0] i2c_data,
  output logic        i2c_go,
  input  logic        i2c_end,
  input  logic        i2c_ack
);

  localparam int RW = $clog2(MAX_RETRY + 1) + 1;
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [TO_W-1:0] GAP_LAST  = (RETRY_GAP > 0) ? TO_W'(RETRY_GAP - 1) : '0;
  localparam logic [RW-1:0]   RETRY_MAX = RW'(MAX_RETRY);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_RELEASE, S_GAP, S_RESP} state_t;

  state_t          r_state, w_next;
  logic [TO_W-1:0] r_cnt;
  logic [RW-1:0]   r_retry;
  logic [23:0]     r_data;
  logic            r_owner, r_rr_last, r_nack, r_err, r_tmo;
  logic            r_req0_ready, r_req1_ready, r_go, r_busy;
  logic            r_done, r_done_id, r_done_err, r_tmo_flag;
  logic            w_grant, w_gnt_id, w_err_nxt, w_tmo_nxt, w_nack_nxt, w_retry_inc;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_grant     = 1'b0;
    w_gnt_id    = 1'b0;
    w_err_nxt   = r_err;
    w_tmo_nxt   = r_tmo;
    w_nack_nxt  = r_nack;
    w_retry_inc = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req0_valid || req1_valid) begin
          w_grant    = 1'b1;
          w_gnt_id   = (req0_valid && req1_valid) ? ~r_rr_last : req1_valid;
          w_err_nxt  = 1'b0;
          w_tmo_nxt  = 1'b0;
          w_nack_nxt = 1'b0;
          w_next     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (i2c_end) begin
          w_nack_nxt = i2c_ack;
          w_next     = S_RELEASE;
        end else if (r_cnt == TO_LAST) begin
          w_err_nxt = 1'b1;
          w_tmo_nxt = 1'b1;
          w_next    = S_RELEASE;
        end
      end
      S_RELEASE: begin
        // wait for END to fall so a stale END never completes the re-issue
        if (r_tmo) begin
          w_next = S_RESP;
        end else if (!i2c_end) begin
          if (r_nack && (r_retry < RETRY_MAX)) begin
            w_retry_inc = 1'b1;
            w_next      = S_GAP;
          end else begin
            w_err_nxt = r_nack;
            w_next    = S_RESP;
          end
        end
      end
      S_GAP: begin
        if (r_cnt == GAP_LAST) w_next = S_ISSUE;
      end
      S_RESP: begin
        w_err_nxt = 1'b0;
        w_tmo_nxt = 1'b0;
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cnt        <= '0;
      r_retry      <= '0;
      r_data       <= '0;
      r_owner      <= 1'b0;
      r_rr_last    <= 1'b1;
      r_nack       <= 1'b0;
      r_err        <= 1'b0;
      r_tmo        <= 1'b0;
      r_req0_ready <= 1'b0;
      r_req1_ready <= 1'b0;
      r_go         <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_done_id    <= 1'b0;
      r_done_err   <= 1'b0;
      r_tmo_flag   <= 1'b0;
    end else begin
      r_nack <= w_nack_nxt;
      r_err  <= w_err_nxt;
      r_tmo  <= w_tmo_nxt;
      if (w_next != r_state)                          r_cnt <= '0;
      else if (r_state == S_ISSUE || r_state == S_GAP) r_cnt <= r_cnt + 1'b1;
      if (w_grant) begin
        r_data    <= w_gnt_id ? req1_data : req0_data;
        r_owner   <= w_gnt_id;
        r_rr_last <= w_gnt_id;
        r_retry   <= '0;
      end else if (w_retry_inc) begin
        r_retry <= r_retry + 1'b1;
      end
      // outputs are registered from the next state so they move only with a state change
      r_req0_ready <= w_grant & ~w_gnt_id;
      r_req1_ready <= w_grant & w_gnt_id;
      r_go         <= (w_next == S_ISSUE);
      r_busy       <= (w_next == S_ISSUE) || (w_next == S_RELEASE) || (w_next == S_GAP);
      r_done       <= (w_next == S_RESP);
      r_done_id    <= (w_next == S_RESP) & r_owner;
      r_done_err   <= (w_next == S_RESP) & w_err_nxt;
      r_tmo_flag   <= (w_next == S_RESP) & w_tmo_nxt;
    end
  end

  assign req0_ready   = r_req0_ready;
  assign req1_ready   = r_req1_ready;
  assign done         = r_done;
  assign done_id      = r_done_id;
  assign done_err     = r_done_err;
  assign timeout_flag = r_tmo_flag;
  assign busy         = r_busy;
  assign i2c_data     = r_data;
  assign i2c_go       = r_go;

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// tb/tb_i2c_cmd_arbiter.sv - directed vector bench for i2c_cmd_arbiter with an I2C controller model
// Inputs change and outputs are sampled on the falling clock edge.
module tb_i2c_cmd_arbiter;

  localparam int GAP = 10;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [23:0] req0_data = '0, req1_data = '0;
  logic        req0_ready, req1_ready, done, done_id, done_err, timeout_flag, busy;
  logic [23:0] i2c_data;
  logic        i2c_go;
  logic        i2c_end = 1'b0, i2c_ack = 1'b0;

  int n_chk = 0, n_miss = 0;

  int m_delay = 4, m_nacks = 0, m_attempt = 0, m_cnt = 0;
  bit m_hang = 1'b0, prev_go = 1'b0;
  int go_cnt = 0, cur_hi = 0, last_hi = 0, cur_lo = 0, min_lo = 1000000;

  i2c_cmd_arbiter #(.MAX_RETRY(3), .RETRY_GAP(GAP), .TIMEOUT_CYC(100), .TO_W(21)) dut (
    .CLK(CLK), .RST(RST),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .done(done), .done_id(done_id), .done_err(done_err), .timeout_flag(timeout_flag),
    .busy(busy), .i2c_data(i2c_data), .i2c_go(i2c_go), .i2c_end(i2c_end), .i2c_ack(i2c_ack)
  );

  always #5 CLK = ~CLK;

  // controller model: END after m_delay GO cycles, NACK on the first m_nacks attempts
  always @(negedge CLK) begin
    if (!i2c_go) begin
      i2c_end = 1'b0;
      i2c_ack = 1'b0;
      m_cnt   = 0;
      if (prev_go) cur_lo = 0;
      cur_lo++;
    end else begin
      if (!prev_go) begin
        go_cnt++;
        cur_hi = 0;
        if (go_cnt > 1 && cur_lo < min_lo) min_lo = cur_lo;
      end
      cur_hi++;
      last_hi = cur_hi;
      if (!m_hang && !i2c_end) begin
        m_cnt++;
        if (m_cnt >= m_delay) begin
          i2c_end = 1'b1;
          i2c_ack = (m_attempt < m_nacks);
          m_attempt++;
        end
      end
    end
    prev_go = i2c_go;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ready0"}, req0_ready, 0);
    chk({tag, "_ready1"}, req1_ready, 0);
    chk({tag, "_done"}, {done, done_id, done_err, timeout_flag}, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_go"}, i2c_go, 0);
    chk({tag, "_data"}, i2c_data, 0);
  endtask

  typedef struct {
    bit          v0, v1;
    logic [23:0] d0, d1;
    int          delay, nacks;
    bit          hang;
    bit          exp_id;
    logic [23:0] exp_data;
    bit          exp_err, exp_tmo;
    int          exp_gos, exp_hi;
  } vec_t;

  vec_t vt[7];

  task automatic run_vec(input vec_t v, input int idx);
    bit got = 1'b0, fin = 1'b0;
    int nrdy = 0;
    @(negedge CLK);
    m_delay = v.delay; m_nacks = v.nacks; m_hang = v.hang; m_attempt = 0;
    go_cnt = 0; min_lo = 1000000;
    req0_valid = v.v0; req0_data = v.d0;
    req1_valid = v.v1; req1_data = v.d1;
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      @(negedge CLK);
      if (req0_ready) nrdy++;
      if (req1_ready) nrdy++;
      if (!got && (req0_ready || req1_ready)) begin
        got = 1'b1;
        chk($sformatf("v%0d_grant_cycle", idx), cyc, 0);
        chk($sformatf("v%0d_grant_id", idx), req1_ready, v.exp_id);
        chk($sformatf("v%0d_data_latch", idx), i2c_data, v.exp_data);
        chk($sformatf("v%0d_busy_go", idx), {busy, i2c_go}, 2'b11);
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data = 24'hFFFFFF; req1_data = 24'hFFFFFF;
      end
      if (done) begin
        fin = 1'b1;
        chk($sformatf("v%0d_done_id", idx), done_id, v.exp_id);
        chk($sformatf("v%0d_done_err", idx), done_err, v.exp_err);
        chk($sformatf("v%0d_timeout_flag", idx), timeout_flag, v.exp_tmo);
        chk($sformatf("v%0d_busy_at_done", idx), busy, 0);
        chk($sformatf("v%0d_data_held", idx), i2c_data, v.exp_data);
        chk($sformatf("v%0d_go_pulses", idx), go_cnt, v.exp_gos);
        chk($sformatf("v%0d_go_high_len", idx), last_hi, v.exp_hi);
        chk($sformatf("v%0d_retry_gap_ok", idx), min_lo >= GAP, 1);
        chk($sformatf("v%0d_ready_pulses", idx), nrdy, 1);
      end
    end
    if (!fin) chk($sformatf("v%0d_done_timeout", idx), 0, 1);
  endtask

  initial begin
    bit seen_go = 1'b0;
    bit prev_busy = 1'b0;
    int k = 0, ndone = 0;

    vt[0] = '{1, 0, 24'h34001A, 24'h000000, 50, 0,  0, 0, 24'h34001A, 0, 0, 1, 50};
    vt[1] = '{1, 1, 24'h340C05, 24'h1A0203, 5,  0,  0, 1, 24'h1A0203, 0, 0, 1, 5};
    vt[2] = '{1, 1, 24'h340411, 24'h1A0304, 3,  2,  0, 0, 24'h340411, 0, 0, 3, 3};
    vt[3] = '{0, 1, 24'h000000, 24'h1A0777, 3,  99, 0, 1, 24'h1A0777, 1, 0, 4, 3};
    vt[4] = '{1, 0, 24'h34ABCD, 24'h000000, 0,  0,  1, 0, 24'h34ABCD, 1, 1, 1, 100};
    vt[5] = '{0, 1, 24'h000000, 24'h1A5555, 1,  0,  0, 1, 24'h1A5555, 0, 0, 1, 1};
    vt[6] = '{1, 1, 24'h34AAAA, 24'h1A0001, 2,  0,  0, 0, 24'h34AAAA, 0, 0, 1, 2};

    repeat (3) @(negedge CLK);
    chk_idle_outputs("reset");
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    chk_idle_outputs("idle");

    for (int i = 0; i < 7; i++) run_vec(vt[i], i);

    // reset in the middle of a hung transfer, with req0 pending behind it
    @(negedge CLK);
    m_hang = 1'b1; m_attempt = 0; m_nacks = 0;
    req1_valid = 1'b1; req1_data = 24'h1A0F0F;
    for (int cyc = 0; cyc < 50 && !seen_go; cyc++) begin
      @(negedge CLK);
      if (req1_ready) req1_valid = 1'b0;
      if (i2c_go) seen_go = 1'b1;
    end
    chk("rst_seq_go_seen", seen_go, 1);
    repeat (5) @(negedge CLK);
    req0_valid = 1'b1; req0_data = 24'h340101;
    req1_valid = 1'b1; req1_data = 24'h1A0202;
    #2 RST = 1'b1;
    #1;
    chk("async_rst_go", i2c_go, 0);
    chk("async_rst_busy", busy, 0);
    @(negedge CLK);
    chk_idle_outputs("mid_rst");
    m_hang = 1'b0; m_delay = 4;
    RST = 1'b0;

    // both valid held for four commands: strict alternation starting with req0
    for (int cyc = 0; cyc < 2000 && ndone < 4; cyc++) begin
      @(negedge CLK);
      if (req0_ready || req1_ready) begin
        chk($sformatf("alt%0d_order", k), req1_ready, k % 2);
        chk($sformatf("alt%0d_single_ready", k), req0_ready & req1_ready, 0);
        chk($sformatf("alt%0d_no_overlap", k), prev_busy, 0);
        k++;
      end
      if (done) begin
        chk($sformatf("alt_done%0d_id", ndone), done_id, ndone % 2);
        chk($sformatf("alt_done%0d_err", ndone), done_err, 0);
        ndone++;
        if (ndone == 4) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      end
      prev_busy = busy;
    end
    chk("alt_grant_count", k, 4);
    chk("alt_done_count", ndone, 4);
    repeat (4) @(negedge CLK);
    chk("final_idle_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_miss);
    $finish;
  end

endmodule

// File: doc/i2c_cmd_arbiter.md
Name: i2c_cmd_arbiter

Overview:
Shares the single I2C_Controller (24-bit {addr,reg,data} write engine with GO/END/ACK) between two command sources: req0 = codec boot sequencer, req1 = runtime control (input-mode/volume changes). Round-robin arbitration, NACK retry with gap, and a watchdog timeout. It sits between the command sources and the I2C_Controller, and reports per-command completion status back to the requester.

Parameters:
MAX_RETRY, 3, re-issues after a NACK before reporting failure (0 = no retry)
RETRY_GAP, 1000, idle CLK cycles between a NACK and the re-issue
TIMEOUT_CYC, 2000000, CLK cycles GO may stay high without END before abort
TO_W, 21, width of the timeout/gap counter (must hold max(TIMEOUT_CYC, RETRY_GAP))

Ports:
CLK  in  1  system clock; the only clock
RST  in  1  asynchronous, active-high reset
req0_valid  in  1  requester 0 has a command
req0_data  in  24  {slave_addr[7:0], reg_word[15:0]}
req0_ready  out  1  1-cycle pulse: req0 command accepted
req1_valid  in  1  requester 1 has a command
req1_data  in  24  same format as req0_data
req1_ready  out  1  1-cycle pulse: req1 command accepted
done  out  1  1-cycle pulse: current command finished
done_id  out  1  requester that owned the finished command
done_err  out  1  valid with done: 1 = retries exhausted or timeout
timeout_flag  out  1  valid with done: 1 = failure cause was timeout
busy  out  1  high from acceptance until done
i2c_data  out  24  to I2C_Controller I2C_DATA
i2c_go  out  1  to I2C_Controller GO
i2c_end  in  1  from I2C_Controller END, already synchronised to CLK
i2c_ack  in  1  from I2C_Controller ACK; 1 = NACK seen, sampled when i2c_end rises

Behaviour:
- Reset (any time, including mid-transfer): state=IDLE; all outputs 0; i2c_data=0; rr_last=1 (req0 wins the first tie); retry_cnt=0; counters=0. An in-flight I2C transfer is abandoned because GO drops.
- IDLE: evaluate valids each cycle.
  - Only one valid: grant it.
  - Both valid: grant the one not equal to rr_last.
  - On grant, in the same cycle: pulse reqN_ready; latch data into i2c_data; set owner=N and rr_last=N; retry_cnt=0; busy=1; go to ISSUE.
  - Requesters must hold valid/data stable until ready. Data is latched at grant; later changes are ignored.
- ISSUE: i2c_go=1; to_cnt increments each cycle.
  - i2c_end=1: capture nack=i2c_ack; go to RELEASE.
  - to_cnt reaches TIMEOUT_CYC-1 with no i2c_end: set err=1, tmo=1; go to RELEASE.
- RELEASE: i2c_go=0; wait for i2c_end=0, so END from the previous transfer is never re-used.
  - If tmo=1: skip the wait, go straight to RESP.
  - Else if nack=1 and retry_cnt<MAX_RETRY: retry_cnt++; go to GAP.
  - Else if nack=1: err=1; go to RESP.
  - Else: go to RESP.
- GAP: count RETRY_GAP cycles with i2c_go=0, then return to ISSUE with to_cnt cleared and i2c_data unchanged.
- RESP: single cycle. done=1, done_id=owner, done_err=err, timeout_flag=tmo; busy=0; clear err/tmo; go to IDLE. A new grant is possible on the next cycle at the earliest.
- Minimum latency, grant to done with an immediate ACK: ISSUE ≥1 + RELEASE ≥1 + RESP 1 = 3 cycles plus controller time.
- Owner retracting valid mid-transfer: no effect; the command completes.
- Simultaneous valid on both sides every transaction: strict alternation 0,1,0,1.
- i2c_go transitions only on a state change (glitch-free, registered).

Test Plan:
- req0 only, data 24'h34_001A; controller model raises END after 50 cycles with ACK=0 -> req0_ready at cycle 1; i2c_data=24'h34001A; i2c_go high ~50 cycles; done=1, done_id=0, done_err=0.
- req0 and req1 valid together continuously for 4 commands -> grant order 0,1,0,1; exactly one ready pulse per grant; busy never overlaps.
- Model NACKs twice, then ACKs (MAX_RETRY=3, RETRY_GAP=10) -> three GO assertions separated by ≥10 low cycles; done_err=0.
- Model always NACKs -> 4 GO assertions total; done_err=1, timeout_flag=0.
- Model never raises END (TIMEOUT_CYC=100) -> GO drops after 100 cycles; done_err=1, timeout_flag=1; arbiter accepts the next request.
- RST asserted while in ISSUE -> i2c_go=0 and busy=0 immediately (asynchronous); after release, a pending req0 is granted first.
